// File: rtl/lcg_stim_pkg.sv
// Shared constants, FSM state type and sizing helpers for the LCG stimulus generator.
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MUL = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC = 32'h3039;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PRESENT,
    DONE
  } state_e;

  function automatic int nwords(input int out_w);
    return (out_w + 31) / 32;
  endfunction

  // Index width never collapses to zero bits, even for a single-word vector.
  function automatic int idx_width(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/lcg_stim_gen_if.sv
// Stimulus vector channel: valid/ready handshake carrying one OUT_W-bit vector per transfer.
interface lcg_stim_gen_if #(
  parameter int OUT_W = 261
);

  logic [OUT_W-1:0] stim_data;
  logic             stim_vld;
  logic             stim_rdy;

  modport master (
    output stim_data,
    output stim_vld,
    input  stim_rdy
  );

  modport slave (
    input  stim_data,
    input  stim_vld,
    output stim_rdy
  );

endinterface

// File: rtl/lcg_step.sv
// One combinational LCG step: y = x*LCG_MUL + LCG_INC, wrapping mod 2^32.
module lcg_step
  import lcg_stim_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  assign y = x * LCG_MUL + LCG_INC;

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG stimulus source: NW+1 cycles start/accept -> valid (2 with LCG_STIM_PARALLEL_EN).
// Holds vector and LCG state indefinitely while stim_rdy is low.
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int          OUT_W    = 261,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] SEED_RST = 32'd2272528809
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          seed_in,
  input  logic [CNT_W-1:0]     num_vecs,
  lcg_stim_gen_if.master       stim,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     vec_cnt,
  output logic [31:0]          lcg_state
);

  localparam int NW = nwords(OUT_W);

  state_e             state_q, state_d;
  logic [31:0]        lcg_q, lcg_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;

  logic [OUT_W-1:0]   fill_data;
  logic [31:0]        fill_lcg;
  logic               fill_last;

`ifdef LCG_STIM_PARALLEL_EN
  // Whole vector in one FILL cycle through a chain of NW steppers.
  logic [31:0] chain [NW+1];

  assign chain[0] = lcg_q;

  for (genvar k = 0; k < NW; k++) begin : g_chain
    lcg_step u_step (
      .x (chain[k]),
      .y (chain[k+1])
    );
  end

  always_comb begin
    fill_data = '0;
    for (int k = 0; k < NW; k++) begin
      fill_data = fill_data | (OUT_W'(chain[k+1]) << (32 * k));
    end
  end

  assign fill_lcg  = chain[NW];
  assign fill_last = 1'b1;
`else
  localparam int IDX_W = idx_width(NW);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      step_y;

  lcg_step u_step (
    .x (lcg_q),
    .y (step_y)
  );

  // Shifting a zero-extended word truncates the final partial word for free.
  assign fill_data = (data_q & ~(OUT_W'(32'hFFFF_FFFF) << {idx_q, 5'd0}))
                   | (OUT_W'(step_y) << {idx_q, 5'd0});
  assign fill_lcg  = step_y;
  assign fill_last = (idx_q == IDX_W'(NW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    lcg_d   = lcg_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
`ifndef LCG_STIM_PARALLEL_EN
    idx_d   = idx_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lcg_d   = seed_in;
          cnt_d   = '0;
          num_d   = num_vecs;
          state_d = (num_vecs == '0) ? DONE : FILL;
`ifndef LCG_STIM_PARALLEL_EN
          idx_d   = '0;
`endif
        end
      end
      FILL: begin
        lcg_d  = fill_lcg;
        data_d = fill_data;
`ifndef LCG_STIM_PARALLEL_EN
        idx_d  = fill_last ? '0 : idx_q + 1'b1;
`endif
        if (fill_last) begin
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (stim.stim_rdy) begin
          if (cnt_q != num_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          state_d = (cnt_q + CNT_W'(1) == num_q) ? DONE : FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lcg_q   <= SEED_RST;
      data_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      lcg_q   <= lcg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
    end
  end

  assign stim.stim_vld  = (state_q == PRESENT);
  assign stim.stim_data = data_q;
  assign busy           = (state_q == FILL) || (state_q == PRESENT);
  assign done           = (state_q == DONE);
  assign vec_cnt        = cnt_q;
  assign lcg_state      = lcg_q;

endmodule
